// File: rtl/fm_float_pipe.sv
// Three-stage floating-point multiplier with radix-4 Booth partial products,
// optional per-product column truncation, and a valid/ready output handshake.
module fm_float_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 10,
  parameter int TRUNC = MAN_W,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags,
  output logic [CNT_W-1:0]       res_cnt
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int SIG_W = MAN_W + 2;
  localparam int NPP   = (SIG_W + 1) / 2;
  localparam int BX_W  = 2 * NPP + 1;
  localparam int P_W   = 2 * MAN_W + 2;
  localparam int SW    = 2 * MAN_W + 8;
  localparam int EW    = EXP_W + 2;
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX  = (1 << EXP_W) - 1;
  localparam logic [MAN_W-1:0] QNAN_M = MAN_W'(1) << (MAN_W - 1);

  logic adv;

  // ---------------- S1: decode, classify, Booth partial products
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic [SIG_W-1:0] sig_a, sig_b;
  logic [BX_W-1:0]  bx;
  logic signed [SW-1:0] ax1, ax2, pp_sel;
  logic signed [SW-1:0] pp_d [NPP];
  logic signed [SW-1:0] pp_q [NPP];
  logic signed [EW-1:0] e_d, s1_e_q;
  logic s1_valid_q, s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
  logic nan_d, inf_d, zero_d;

  assign ea = a[W-2:MAN_W];
  assign eb = b[W-2:MAN_W];
  assign ma = a[MAN_W-1:0];
  assign mb = b[MAN_W-1:0];

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (ma == '0);
  assign b_inf  = (eb == '1) && (mb == '0);
  assign a_nan  = (ea == '1) && (ma != '0);
  assign b_nan  = (eb == '1) && (mb != '0);

  assign nan_d  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
  assign inf_d  = a_inf | b_inf;
  assign zero_d = a_zero | b_zero;

  assign sig_a = {2'b01, ma};
  assign sig_b = {2'b01, mb};
  // Multiplier MSB is always 0, so zero-extension keeps the Booth recoding exact.
  assign bx    = BX_W'({sig_b, 1'b0});
  assign e_d   = $signed(EW'(ea)) + $signed(EW'(eb)) - $signed(EW'(BIAS));

  always_comb begin
    ax1    = $signed(SW'(sig_a));
    ax2    = ax1 <<< 1;
    pp_sel = '0;
    for (int unsigned i = 0; i < NPP; i++) begin
      case (bx[2*i +: 3])
        3'b001, 3'b010: pp_sel = ax1;
        3'b011:         pp_sel = ax2;
        3'b100:         pp_sel = -ax2;
        3'b101, 3'b110: pp_sel = -ax1;
        default:        pp_sel = '0;
      endcase
      pp_d[i] = pp_sel <<< (2 * i);
    end
  end

  // ---------------- S2: truncated summation
  logic signed [SW-1:0] acc;
  logic [P_W-1:0]       prod_d, s2_prod_q;
  logic signed [EW-1:0] s2_e_q;
  logic s2_valid_q, s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q;

  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < NPP; i++) begin
      acc = acc + (pp_q[i] >>> TRUNC);
    end
    acc = acc <<< TRUNC;
  end

  assign prod_d = acc[P_W-1:0];

  // ---------------- S3: normalize, override, pack
  logic signed [EW-1:0] e_n;
  logic [MAN_W-1:0]     m_n;
  logic [W-1:0]         result_d, result_q;
  logic [3:0]           flags_d, flags_q;
  logic                 out_valid_q;
  logic [CNT_W-1:0]     cnt_q;

  always_comb begin
    if (s2_prod_q[P_W-1]) begin
      m_n = s2_prod_q[P_W-2 -: MAN_W];
      e_n = s2_e_q + $signed(EW'(1));
    end else begin
      m_n = s2_prod_q[P_W-3 -: MAN_W];
      e_n = s2_e_q;
    end
    result_d = {s2_sign_q, e_n[EXP_W-1:0], m_n};
    flags_d  = '0;
    if (s2_nan_q) begin
      result_d = {1'b0, {EXP_W{1'b1}}, QNAN_M};
      flags_d  = 4'b1000;
    end else if (s2_inf_q) begin
      result_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d  = 4'b0100;
    end else if (s2_zero_q) begin
      result_d = {s2_sign_q, {(W-1){1'b0}}};
    end else if (e_n >= $signed(EW'(EMAX))) begin
      result_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d  = 4'b0110;
    end else if (e_n <= $signed(EW'(0))) begin
      result_d = {s2_sign_q, {(W-1){1'b0}}};
      flags_d  = 4'b0001;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{acc[SW-1:P_W], s2_prod_q[MAN_W-1:0]};

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;
  assign res_cnt   = cnt_q;

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      cnt_q       <= '0;
    end else begin
      if (out_valid_q && out_ready) cnt_q <= cnt_q + CNT_W'(1);
      if (adv) begin
        s1_valid_q  <= in_valid;
        s2_valid_q  <= s1_valid_q;
        out_valid_q <= s2_valid_q;
        result_q    <= result_d;
        flags_q     <= flags_d;
      end
    end
  end

  // Datapath registers; contents are only meaningful alongside their valid bit
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign_q <= a[W-1] ^ b[W-1];
      s1_nan_q  <= nan_d;
      s1_inf_q  <= inf_d;
      s1_zero_q <= zero_d;
      s1_e_q    <= e_d;
      pp_q      <= pp_d;
      s2_sign_q <= s1_sign_q;
      s2_nan_q  <= s1_nan_q;
      s2_inf_q  <= s1_inf_q;
      s2_zero_q <= s1_zero_q;
      s2_e_q    <= s1_e_q;
      s2_prod_q <= prod_d;
    end
  end

endmodule

// File: doc/fm_float_pipe.md
FM_FLOAT_PIPE -- requirements
Module: fm_float_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 10, stored-mantissa width; word width W = 1+EXP_W+MAN_W, which is 19 at the defaults (tf32 layout {sign, exp, mant}).
REQ-003 SHALL have parameter TRUNC, default MAN_W, the number of low product columns dropped per partial product (0 = exact multiply).
REQ-004 SHALL have parameter CNT_W, default 16, result-counter width.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  operand pair valid.
REQ-008 in_ready  output  1  block accepts the operand pair this cycle.
REQ-009 a, b  input  W each  operands, sign at [W-1], exponent at [W-2:MAN_W], mantissa at [MAN_W-1:0].
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 result  output  W  product in the same format.
REQ-013 flags  output  4  {nan, inf, ovf, unf}, aligned with result.
REQ-014 res_cnt  output  CNT_W  count of results delivered.

Function
REQ-015 SHALL be a 3-stage pipeline: S1 field decode, special-case classification and radix-4 Booth partial-product generation; S2 truncated partial-product summation; S3 normalize, special-case override and pack.
REQ-016 SHALL have a latency of exactly 3 cycles from an accepted input to out_valid, with one result per cycle sustained while out_ready=1.
REQ-017 SHALL define the advance enable as adv = !out_valid || out_ready; when adv=1 all stages shift, and when adv=0 all stage registers, including the valid bits, hold.
REQ-018 SHALL drive in_ready = adv combinationally; a transfer occurs when in_valid && in_ready, and a bubble enters S1 otherwise.
REQ-019 SHALL hold result and flags stable while out_valid=1 && out_ready=0.
REQ-020 SHALL form the significands as {2'b01, mant} of width MAN_W+2, treated as unsigned.
REQ-021 SHALL compute the approximate product as the sum over i of floor(PP_i / 2^TRUNC), where PP_i is the i-th signed radix-4 Booth partial product already weighted by 4^i; the sum is then scaled by 2^TRUNC.
REQ-022 SHALL use the sign s = sa ^ sb, and the exponent as a signed (EXP_W+2)-bit value e = ea + eb - BIAS, where BIAS = 2^(EXP_W-1)-1.
REQ-023 SHALL normalize as follows: if product bit 2*MAN_W+1 is 1, take the mantissa from the bits just below it and set e = e+1; otherwise take the mantissa from below bit 2*MAN_W; rounding is truncation.
REQ-024 SHALL treat exponent field 0 as zero, flushing denormals: the result is {s, 0, 0} with no flags.
REQ-025 SHALL handle an all-ones exponent field as follows: mantissa != 0 means NaN; mantissa == 0 means infinity.
REQ-026 SHALL produce the canonical NaN {0, all-ones, 1 followed by MAN_W-1 zeros} with nan=1 when either operand is NaN or when infinity is multiplied by zero.
REQ-027 SHALL return {s, all-ones, 0} with inf=1 when an operand is infinity and the other is finite and nonzero.
REQ-028 SHALL apply the following only to finite nonzero operands: normalized e >= 2^EXP_W-1 gives {s, all-ones, 0} with ovf=1 and inf=1; e <= 0 gives {s, 0, 0} with unf=1.
REQ-029 SHALL apply special-case precedence in the order NaN > infinity > zero > overflow/underflow > normal.
REQ-030 SHALL increment res_cnt on each out_valid && out_ready, wrapping modulo 2^CNT_W.

Reset
REQ-031 SHALL clear all stage valid bits, out_valid, result, flags and res_cnt on rst=1 at a clock edge.
REQ-032 SHALL drive in_ready = 1 during and after reset, since out_valid = 0.
REQ-033 SHALL discard in-flight operations when rst is asserted mid-operation: no result appears for them, and a transfer coinciding with rst is dropped.
REQ-034 SHALL deliver the first accepted input after rst is released exactly 3 cycles later.

Verification
REQ-035 SHALL cover the exact case: TRUNC=0, a=0x1FE00 (1.5), b=0x1FE00, out_ready=1 -> result=0x20080 (2.25), flags=0, 3 cycles after acceptance.
REQ-036 SHALL cover the approximate case at defaults: a=b=0x1FC00 (1.0) -> 0x1FC00; random operands -> result matches a reference model of REQ-021 to REQ-023 bit-exactly.
REQ-037 SHALL cover special values: a=0x3FC00 (+inf) with b=0x00000 -> 0x3FE00, nan=1; a=0x3FC00 with b=0x5FC00 (-1.0) -> 0x7FC00, inf=1; a=0x00123 (denormal) with b=0x1FC00 -> 0x00000.
REQ-038 SHALL cover overflow and underflow: a=b=0x3F800 -> 0x3FC00 with ovf=1 and inf=1; a=b=0x00400 -> 0x00000 with unf=1.
REQ-039 SHALL cover backpressure: a stream of 5 inputs with out_ready held 0 for 4 cycles -> in_ready drops once out_valid=1, no result is lost or duplicated, results stay in order, and res_cnt=5.
REQ-040 SHALL cover reset mid-stream: rst pulsed with 2 operations in flight -> out_valid stays 0 until a new input has been accepted and 3 cycles have elapsed, and res_cnt=0.
